// File: rtl/lsb_mem_responder.sv
// Purpose: serialises load/store-buffer requests and 4-byte instruction fetches into byte accesses on the RAM/IO bus.
// Latency: welcome 1 cycle after request; loads/fetches complete N+1 cycles after entry, stores N cycles after welcome.
// Backpressure: one request in flight, accepted only in IDLE (data beats fetch); rdy_in low freezes all state; a full IO buffer stalls IO stores.
module lsb_mem_responder #(
    parameter int         ADDR_W     = 32,
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear_up,
    input  logic              lsb_visit_mem,
    input  logic [6:0]        op_type_in,
    input  logic [2:0]        op_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       data_in,
    output logic              cache_welcome_signal,
    output logic              cache_ready,
    output logic              is_load,
    output logic [31:0]       data_out,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_inst,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {IDLE, LOAD, STORE, FETCH, IO_WAIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [31:0]       result_q, result_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              welcome_q, welcome_d;
    logic              ready_q, ready_d;
    logic              is_load_q, is_load_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              if_ready_q, if_ready_d;
    logic [31:0]       if_inst_q, if_inst_d;

    logic [2:0]        n_bytes;
    logic [2:0]        cnt_nx;
    logic [1:0]        byte_idx;
    logic [31:0]       result_ins;

    function automatic logic [2:0] size_of(input logic [1:0] f);
        case (f)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] r, input logic [2:0] f);
        case (f)
            3'b000:  return {{24{r[7]}}, r[7:0]};
            3'b001:  return {{16{r[15]}}, r[15:0]};
            3'b100:  return {24'd0, r[7:0]};
            3'b101:  return {16'd0, r[15:0]};
            default: return r;
        endcase
    endfunction

    // Access size, next counter and the result with the byte now on mem_din merged in (byte cnt-1 arrives while cnt is driven).
    always_comb begin
        n_bytes    = (state_q == FETCH) ? 3'd4 : size_of(op_q[1:0]);
        cnt_nx     = cnt_q + 3'd1;
        byte_idx   = cnt_q[1:0] - 2'd1;
        result_ins = result_q;
        result_ins[{byte_idx, 3'b000} +: 8] = mem_din;
    end

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        op_d       = op_q;
        sdata_d    = sdata_q;
        result_d   = result_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        welcome_d  = 1'b0;
        ready_d    = 1'b0;
        if_ready_d = 1'b0;
        is_load_d  = is_load_q;
        data_out_d = data_out_q;
        if_inst_d  = if_inst_q;
        case (state_q)
            IDLE: begin
                // A request coinciding with a flush belongs to squashed work and is dropped.
                if (!rob_clear_up) begin
                    if (lsb_visit_mem) begin
                        base_d    = addr_in;
                        op_d      = op_in;
                        sdata_d   = data_in;
                        cnt_d     = 3'd0;
                        result_d  = 32'd0;
                        welcome_d = 1'b1;
                        mem_a_d   = addr_in;
                        if (op_type_in == OP_STORE) begin
                            if (addr_in[17:16] == IO_BASE_HI && io_buffer_full) begin
                                state_d  = IO_WAIT;
                                mem_wr_d = 1'b0;
                            end else begin
                                state_d    = STORE;
                                mem_dout_d = data_in[7:0];
                                mem_wr_d   = 1'b1;
                            end
                        end else begin
                            state_d  = LOAD;
                            mem_wr_d = 1'b0;
                        end
                    end else if (if_req) begin
                        base_d   = if_addr;
                        cnt_d    = 3'd0;
                        result_d = 32'd0;
                        mem_a_d  = if_addr;
                        mem_wr_d = 1'b0;
                        state_d  = FETCH;
                    end
                end
            end
            LOAD, FETCH: begin
                if (rob_clear_up) begin
                    state_d  = IDLE;
                    mem_wr_d = 1'b0;
                end else begin
                    if (cnt_q != 3'd0) result_d = result_ins;
                    if (cnt_q == n_bytes) begin
                        state_d = IDLE;
                        if (state_q == LOAD) begin
                            ready_d    = 1'b1;
                            is_load_d  = 1'b1;
                            data_out_d = extend(result_ins, op_q);
                        end else begin
                            if_ready_d = 1'b1;
                            if_inst_d  = result_ins;
                        end
                    end else begin
                        cnt_d   = cnt_nx;
                        mem_a_d = base_q + ADDR_W'(cnt_nx);
                    end
                end
            end
            STORE: begin
                // Committed stores always run to completion, flush or not.
                if (cnt_q == n_bytes - 3'd1) begin
                    state_d   = IDLE;
                    mem_wr_d  = 1'b0;
                    ready_d   = 1'b1;
                    is_load_d = 1'b0;
                end else begin
                    cnt_d      = cnt_nx;
                    mem_a_d    = base_q + ADDR_W'(cnt_nx);
                    mem_dout_d = sdata_q[{cnt_nx[1:0], 3'b000} +: 8];
                    mem_wr_d   = 1'b1;
                end
            end
            IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_d    = STORE;
                    cnt_d      = 3'd0;
                    mem_a_d    = base_q;
                    mem_dout_d = sdata_q[7:0];
                    mem_wr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; everything holds while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            base_q     <= '0;
            op_q       <= 3'd0;
            sdata_q    <= 32'd0;
            result_q   <= 32'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            welcome_q  <= 1'b0;
            ready_q    <= 1'b0;
            is_load_q  <= 1'b0;
            data_out_q <= 32'd0;
            if_ready_q <= 1'b0;
            if_inst_q  <= 32'd0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            op_q       <= op_d;
            sdata_q    <= sdata_d;
            result_q   <= result_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            welcome_q  <= welcome_d;
            ready_q    <= ready_d;
            is_load_q  <= is_load_d;
            data_out_q <= data_out_d;
            if_ready_q <= if_ready_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign cache_welcome_signal = welcome_q;
    assign cache_ready          = ready_q;
    assign is_load              = is_load_q;
    assign data_out             = data_out_q;
    assign if_ready             = if_ready_q;
    assign if_inst              = if_inst_q;
    assign mem_a                = mem_a_q;
    assign mem_dout             = mem_dout_q;
    // A frozen pipeline must never repeat a write strobe.
    assign mem_wr               = mem_wr_q & rdy_in;
endmodule

// File: tb/tb_lsb_mem_responder.sv
module tb_lsb_mem_responder;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear_up, lsb_visit_mem, if_req, io_buffer_full;
    logic [6:0]  op_type_in;
    logic [2:0]  op_in;
    logic [31:0] addr_in, data_in, if_addr;
    logic        cache_welcome_signal, cache_ready, is_load, if_ready, mem_wr;
    logic [31:0] data_out, if_inst, mem_a;
    logic [7:0]  mem_din, mem_dout;

    typedef struct { int c; logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t        wlog[$];
    logic [7:0] ram [0:1023];
    logic [7:0] ref_mem [0:1023];
    bit         ram_init;
    int         cyc;
    int         checks = 0;
    int         errors = 0;

    lsb_mem_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
        .lsb_visit_mem(lsb_visit_mem), .op_type_in(op_type_in), .op_in(op_in),
        .addr_in(addr_in), .data_in(data_in), .cache_welcome_signal(cache_welcome_signal),
        .cache_ready(cache_ready), .is_load(is_load), .data_out(data_out),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_inst(if_inst),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // Byte RAM with one-cycle read latency; IO space writes are logged only.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (!ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= ref_mem[i];
            ram_init <= 1'b1;
        end
        mem_din <= ram[mem_a[9:0]];
        if (mem_wr === 1'b1) begin
            wlog.push_back('{cyc, mem_a, mem_dout});
            if (mem_a[17:16] != 2'b11) ram[mem_a[9:0]] <= mem_dout;
        end
    end

    function automatic int nbytes(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Little-endian value of N bytes, then two's-complement reinterpretation for signed loads.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
        longint v = 0;
        int n = nbytes(f);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + i;
            v = v + (longint'(ref_mem[ai[9:0]]) << (8 * i));
        end
        if (!f[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        logic [31:0] ai;
        for (int i = 0; i < nbytes(f); i++) begin
            ai = a + i;
            ref_mem[ai[9:0]] = 8'((d >> (8 * i)) & 32'hFF);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_req(input bit st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int wlat, output int rlat, output logic il, output bit tmo);
        int t = 0;
        bit got_w = 0;
        bit done = 0;
        op_type_in = st ? 7'b0100011 : 7'b0000011;
        op_in = f; addr_in = a; data_in = d; lsb_visit_mem = 1'b1;
        wlat = -1; rlat = -1; tmo = 0; rd = 32'd0; il = 1'b0;
        while (!done) begin
            tick(); t++;
            if (!got_w && cache_welcome_signal === 1'b1) begin
                got_w = 1; wlat = t; lsb_visit_mem = 1'b0;
            end else if (got_w && cache_ready === 1'b1) begin
                rlat = t - wlat; rd = data_out; il = is_load; done = 1;
            end
            if (!done && t > 60) begin tmo = 1; lsb_visit_mem = 1'b0; done = 1; end
        end
    endtask

    task automatic test_reset();
        checks++; if (cache_welcome_signal !== 1'b0) begin errors++; $display("FAIL reset_welcome got %b exp 0", cache_welcome_signal); end
        checks++; if (cache_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cache_ready); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready got %b exp 0", if_ready); end
        checks++; if (is_load !== 1'b0) begin errors++; $display("FAIL reset_is_load got %b exp 0", is_load); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
        checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a got %h exp 0", mem_a); end
        checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout got %h exp 0", mem_dout); end
        checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL reset_data_out got %h exp 0", data_out); end
        checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL reset_if_inst got %h exp 0", if_inst); end
    endtask

    task automatic test_lb_lbu();
        logic [31:0] rd; int wl, rl; logic il; bit tmo;
        run_req(1, 3'b000, 32'h100, 32'h80, rd, wl, rl, il, tmo);
        model_store(32'h100, 3'b000, 32'h80);
        run_req(0, 3'b000, 32'h100, 0, rd, wl, rl, il, tmo);
        checks++; if (wl != 1) begin errors++; $display("FAIL lb_welcome_lat got %0d exp 1", wl); end
        checks++; if (rl != 2) begin errors++; $display("FAIL lb_ready_lat got %0d exp 2", rl); end
        checks++; if (il !== 1'b1) begin errors++; $display("FAIL lb_is_load got %b exp 1", il); end
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", rd); end
        run_req(0, 3'b100, 32'h100, 0, rd, wl, rl, il, tmo);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", rd); end
    endtask

    task automatic test_sw();
        logic [31:0] rd; int wl, rl; logic il; bit tmo;
        logic [7:0] eb [4];
        eb[0] = 8'h78; eb[1] = 8'h56; eb[2] = 8'h34; eb[3] = 8'h12;
        wlog.delete();
        run_req(1, 3'b010, 32'h200, 32'h12345678, rd, wl, rl, il, tmo);
        model_store(32'h200, 3'b010, 32'h12345678);
        checks++; if (rl != 4) begin errors++; $display("FAIL sw_ready_lat got %0d exp 4", rl); end
        checks++; if (il !== 1'b0) begin errors++; $display("FAIL sw_is_load got %b exp 0", il); end
        checks++;
        if (wlog.size() != 4) begin errors++; $display("FAIL sw_write_count got %0d exp 4", wlog.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (wlog[i].a !== 32'h200 + i || wlog[i].d !== eb[i] || wlog[i].c != wlog[0].c + i)
            begin errors++; $display("FAIL sw_byte%0d got a=%h d=%h c=%0d exp a=%h d=%h", i, wlog[i].a, wlog[i].d, wlog[i].c - wlog[0].c, 32'h200 + i, eb[i]); end
        end
        run_req(0, 3'b010, 32'h200, 0, rd, wl, rl, il, tmo);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL sw_readback got %h exp 12345678", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, ex; int wl, rl, n; logic il; bit tmo, st; logic [2:0] f;
        for (int k = 0; k < 30; k++) begin
            st = 1'($urandom_range(0, 1));
            case ($urandom_range(0, st ? 2 : 4))
                0: f = 3'b000; 1: f = 3'b001; 2: f = 3'b010; 3: f = 3'b100; default: f = 3'b101;
            endcase
            a = $urandom_range(0, 'h3F0); d = $urandom; n = nbytes(f);
            ex = model_load(a, f);
            wlog.delete();
            run_req(st, f, a, d, rd, wl, rl, il, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL rnd%0d_timeout got timeout exp completion", k); end
            checks++; if (wl != 1) begin errors++; $display("FAIL rnd%0d_welcome_lat got %0d exp 1", k, wl); end
            checks++; if (rl != (st ? n : n + 1)) begin errors++; $display("FAIL rnd%0d_ready_lat got %0d exp %0d", k, rl, st ? n : n + 1); end
            checks++; if (il !== !st) begin errors++; $display("FAIL rnd%0d_is_load got %b exp %b", k, il, !st); end
            if (st) begin
                checks++;
                if (wlog.size() != n) begin errors++; $display("FAIL rnd%0d_write_count got %0d exp %0d", k, wlog.size(), n); end
                else for (int i = 0; i < n; i++) begin
                    checks++;
                    if (wlog[i].a !== a + i || wlog[i].d !== 8'((d >> (8 * i)) & 32'hFF) || wlog[i].c != wlog[0].c + i)
                    begin errors++; $display("FAIL rnd%0d_wbyte%0d got a=%h d=%h exp a=%h d=%h", k, i, wlog[i].a, wlog[i].d, a + i, 8'((d >> (8 * i)) & 32'hFF)); end
                end
                model_store(a, f, d);
            end else begin
                checks++; if (rd !== ex) begin errors++; $display("FAIL rnd%0d_load f=%b a=%h got %h exp %h", k, f, a, rd, ex); end
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_fetch();
        logic [31:0] a; int t, tr;
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, 'h3F0);
            if_addr = a; if_req = 1'b1; t = 0; tr = -1;
            while (tr < 0 && t < 40) begin
                tick(); t++;
                if (if_ready === 1'b1) begin tr = t; if_req = 1'b0; end
            end
            if_req = 1'b0;
            checks++; if (tr != 6) begin errors++; $display("FAIL fetch%0d_lat got %0d exp 6", k, tr); end
            checks++; if (if_inst !== model_load(a, 3'b010)) begin errors++; $display("FAIL fetch%0d_inst got %h exp %h", k, if_inst, model_load(a, 3'b010)); end
        end
    endtask

    task automatic test_back_to_back();
        int t = 0, tw = -1, tc = -1, tf = -1;
        logic [31:0] dv = 0, iv = 0;
        op_type_in = 7'b0000011; op_in = 3'b010; addr_in = 32'h10; lsb_visit_mem = 1'b1;
        if_addr = 32'h0; if_req = 1'b1;
        while (tf < 0 && t < 60) begin
            tick(); t++;
            if (cache_welcome_signal === 1'b1 && tw < 0) begin tw = t; lsb_visit_mem = 1'b0; end
            if (cache_ready === 1'b1 && tc < 0) begin tc = t; dv = data_out; end
            if (if_ready === 1'b1) begin tf = t; iv = if_inst; if_req = 1'b0; end
        end
        lsb_visit_mem = 1'b0; if_req = 1'b0;
        checks++; if (tw != 1) begin errors++; $display("FAIL arb_welcome got %0d exp 1", tw); end
        checks++; if (tc != 6) begin errors++; $display("FAIL arb_data_ready got %0d exp 6", tc); end
        checks++; if (tf != tc + 6) begin errors++; $display("FAIL arb_fetch_ready got %0d exp %0d", tf, tc + 6); end
        checks++; if (dv !== model_load(32'h10, 3'b010)) begin errors++; $display("FAIL arb_data got %h exp %h", dv, model_load(32'h10, 3'b010)); end
        checks++; if (iv !== model_load(32'h0, 3'b010)) begin errors++; $display("FAIL arb_inst got %h exp %h", iv, model_load(32'h0, 3'b010)); end
    endtask

    task automatic test_flush();
        logic [31:0] rd; int wl, rl; logic il; bit tmo; int seen;
        op_type_in = 7'b0000011; op_in = 3'b010; addr_in = 32'h40; lsb_visit_mem = 1'b1;
        seen = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (cache_welcome_signal === 1'b1) lsb_visit_mem = 1'b0;
            rob_clear_up = (t == 3);
            if (cache_ready === 1'b1) seen++;
        end
        rob_clear_up = 1'b0;
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_load_ready got %0d pulses exp 0", seen); end
        if_addr = 32'h20; if_req = 1'b1; seen = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 2) begin rob_clear_up = 1'b1; if_req = 1'b0; end else rob_clear_up = 1'b0;
            if (if_ready === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_fetch_ready got %0d pulses exp 0", seen); end
        op_type_in = 7'b0000011; op_in = 3'b000; addr_in = 32'h44; lsb_visit_mem = 1'b1; rob_clear_up = 1'b1;
        tick();
        lsb_visit_mem = 1'b0; rob_clear_up = 1'b0; seen = 0;
        for (int t = 0; t < 5; t++) begin tick(); if (cache_welcome_signal === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_same_cycle_req got %0d welcomes exp 0", seen); end
        run_req(0, 3'b001, 32'h50, 0, rd, wl, rl, il, tmo);
        checks++; if (wl != 1) begin errors++; $display("FAIL flush_after_welcome got %0d exp 1", wl); end
        checks++; if (rd !== model_load(32'h50, 3'b001)) begin errors++; $display("FAIL flush_after_data got %h exp %h", rd, model_load(32'h50, 3'b001)); end
    endtask

    task automatic test_io_stall();
        int t = 0, tr = -1, early = 0;
        wlog.delete();
        io_buffer_full = 1'b1;
        op_type_in = 7'b0100011; op_in = 3'b000; addr_in = 32'h30000; data_in = 32'hA5; lsb_visit_mem = 1'b1;
        while (tr < 0 && t < 30) begin
            tick(); t++;
            if (cache_welcome_signal === 1'b1) lsb_visit_mem = 1'b0;
            if (t <= 5 && mem_wr !== 1'b0) early++;
            if (cache_ready === 1'b1) tr = t;
            if (t == 5) io_buffer_full = 1'b0;
        end
        lsb_visit_mem = 1'b0; io_buffer_full = 1'b0;
        checks++; if (early != 0) begin errors++; $display("FAIL io_stall_wr got %0d write cycles exp 0", early); end
        checks++; if (tr < 0) begin errors++; $display("FAIL io_ready got timeout exp completion"); end
        checks++;
        if (wlog.size() != 1) begin errors++; $display("FAIL io_write_count got %0d exp 1", wlog.size()); end
        else if (wlog[0].a !== 32'h30000 || wlog[0].d !== 8'hA5) begin errors++; $display("FAIL io_write got a=%h d=%h exp a=00030000 d=a5", wlog[0].a, wlog[0].d); end
    endtask

    task automatic test_rdy_stall();
        int t = 0, tr = -1, bad = 0;
        logic [31:0] d = $urandom;
        wlog.delete();
        op_type_in = 7'b0100011; op_in = 3'b010; addr_in = 32'h300; data_in = d; lsb_visit_mem = 1'b1;
        while (tr < 0 && t < 30) begin
            tick(); t++;
            if (cache_welcome_signal === 1'b1) lsb_visit_mem = 1'b0;
            rdy_in = !(t >= 2 && t <= 4);
            #1;
            if (!rdy_in && mem_wr !== 1'b0) bad++;
            if (cache_ready === 1'b1) tr = t;
        end
        rdy_in = 1'b1; lsb_visit_mem = 1'b0;
        model_store(32'h300, 3'b010, d);
        checks++; if (bad != 0) begin errors++; $display("FAIL rdy_mem_wr got %0d strobes exp 0", bad); end
        checks++;
        if (wlog.size() != 4) begin errors++; $display("FAIL rdy_write_count got %0d exp 4", wlog.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (wlog[i].a !== 32'h300 + i || wlog[i].d !== 8'((d >> (8 * i)) & 32'hFF))
            begin errors++; $display("FAIL rdy_byte%0d got a=%h d=%h exp a=%h d=%h", i, wlog[i].a, wlog[i].d, 32'h300 + i, 8'((d >> (8 * i)) & 32'hFF)); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; int wl, rl; logic il; bit tmo;
        wlog.delete();
        op_type_in = 7'b0100011; op_in = 3'b010; addr_in = 32'h380; data_in = 32'hCAFEF00D; lsb_visit_mem = 1'b1;
        tick(); lsb_visit_mem = 1'b0;
        tick();
        #3 rst_in = 1'b1;
        #1;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL arst_mem_wr got %b exp 0", mem_wr); end
        checks++; if (mem_a !== 32'd0 || mem_dout !== 8'd0) begin errors++; $display("FAIL arst_bus got a=%h d=%h exp 0", mem_a, mem_dout); end
        checks++; if (cache_ready !== 1'b0 || cache_welcome_signal !== 1'b0 || is_load !== 1'b0) begin errors++; $display("FAIL arst_pulses got r=%b w=%b l=%b exp 0", cache_ready, cache_welcome_signal, is_load); end
        tick();
        rst_in = 1'b0;
        ref_mem[10'h380] = 8'h0D;
        checks++; if (wlog.size() != 1) begin errors++; $display("FAIL arst_partial_writes got %0d exp 1", wlog.size()); end
        tick();
        run_req(0, 3'b010, 32'h380, 0, rd, wl, rl, il, tmo);
        checks++; if (rd !== model_load(32'h380, 3'b010)) begin errors++; $display("FAIL arst_after_data got %h exp %h", rd, model_load(32'h380, 3'b010)); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0; lsb_visit_mem = 1'b0; if_req = 1'b0;
        io_buffer_full = 1'b0; op_type_in = 7'd0; op_in = 3'd0; addr_in = 32'd0; data_in = 32'd0; if_addr = 32'd0;
        repeat (3) @(posedge clk_in);
        #1;
        test_reset();
        rst_in = 1'b0;
        tick();
        test_reset();
        test_lb_lbu();
        test_sw();
        test_random();
        test_fetch();
        test_back_to_back();
        test_flush();
        test_io_stall();
        test_rdy_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish before 500us");
        $fatal(1, "watchdog expired");
    end
endmodule
